// File: rtl/fifo_arb_pkg.sv
// Shared types and the round-robin search used by the FIFO write arbiter.
// The search is a plain function so a future read-side scheduler can reuse it.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_e;

    localparam int unsigned RR_MAX = 32;

    // First set bit of req searching upward from last+1, wrapping at n.
    // The loop runs from the farthest candidate to the nearest so the
    // nearest set bit is the final assignment and therefore the winner.
    function automatic int unsigned next_rr(
        input logic [RR_MAX-1:0] req,
        input int unsigned       last,
        input int unsigned       n
    );
        int unsigned idx;
        next_rr = 0;
        for (int unsigned k = RR_MAX; k >= 1; k--) begin
            if (k <= n) begin
                idx = last + k;
                if (idx >= n) begin
                    idx = idx - n;
                end
                if (req[idx]) begin
                    next_rr = idx;
                end
            end
        end
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector: lowest priority goes to last_i,
// highest to last_i+1 (mod NUM_REQ).
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [ID_W-1:0]    last_i,
    output logic [ID_W-1:0]    id_o,
    output logic               found_o
);

    logic [RR_MAX-1:0] req_ext;

    always_comb begin
        req_ext                = '0;
        req_ext[NUM_REQ-1:0]   = req_i;
        id_o    = ID_W'(next_rr(req_ext, 32'(last_i), NUM_REQ));
        found_o = |req_i;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin burst arbiter feeding one async_fifo write port; each grant
// costs one IDLE bubble and writes up to BURST_LEN words.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 8,
    parameter int BURST_LEN  = 4,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            ack,
    input  logic                          fifo_full,
    input  logic                          fifo_almost_full,
    output logic [DATA_WIDTH-1:0]         fifo_w_data,
    output logic                          fifo_w_en,
    output logic                          gnt_valid,
    output logic [ID_W-1:0]               gnt_id
);

    localparam int CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_e        state_q, state_d;
    logic [ID_W-1:0]   owner_q, owner_d;
    logic [ID_W-1:0]   last_q, last_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ID_W-1:0]   pick_id;
    logic              pick_found;
    logic              owner_req;
    logic              write;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_rr_pick (
        .req_i   (req),
        .last_i  (last_q),
        .id_o    (pick_id),
        .found_o (pick_found)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            owner_q <= '0;
            last_q  <= ID_W'(NUM_REQ - 1);
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
        end
    end

    // The write qualifier is gated by rst so a reset edge mid-burst never writes.
    always_comb begin
        owner_req = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                owner_req = req[i];
            end
        end
        write = rst && (state_q == BURST) && owner_req && !fifo_full;
    end

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        last_d  = last_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (pick_found && !fifo_full) begin
                    owner_d = pick_id;
                    cnt_d   = '0;
                    state_d = BURST;
                end
            end
            BURST: begin
                if (!owner_req) begin
                    state_d = IDLE;
                    last_d  = owner_q;
                end else if (!fifo_full) begin
                    cnt_d = cnt_q + CNT_W'(1);
                    if ((cnt_q == CNT_W'(BURST_LEN - 1)) || fifo_almost_full) begin
                        state_d = IDLE;
                        last_d  = owner_q;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        gnt_valid   = 1'b0;
        gnt_id      = '0;
        fifo_w_en   = 1'b0;
        fifo_w_data = '0;
        ack         = '0;
        if (rst && (state_q == BURST)) begin
            gnt_valid = 1'b1;
            gnt_id    = owner_q;
            for (int i = 0; i < NUM_REQ; i++) begin
                if (owner_q == ID_W'(i)) begin
                    fifo_w_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                end
            end
        end
        if (write) begin
            fifo_w_en = 1'b1;
            ack       = NUM_REQ'(1) << owner_q;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter with hand-computed expected outputs.
// Outputs are packed as {gnt_valid, gnt_id, fifo_w_en, fifo_w_data, ack}.
module tb_fifo_wr_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  ack;
    logic        fifo_full;
    logic        fifo_almost_full;
    logic [7:0]  fifo_w_data;
    logic        fifo_w_en;
    logic        gnt_valid;
    logic [1:0]  gnt_id;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wr    = 0;
    int wr_mark;

    fifo_wr_arbiter #(
        .NUM_REQ    (4),
        .DATA_WIDTH (8),
        .BURST_LEN  (4)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .req              (req),
        .req_data         (req_data),
        .ack              (ack),
        .fifo_full        (fifo_full),
        .fifo_almost_full (fifo_almost_full),
        .fifo_w_data      (fifo_w_data),
        .fifo_w_en        (fifo_w_en),
        .gnt_valid        (gnt_valid),
        .gnt_id           (gnt_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [15:0] pk(input logic gv, input logic [1:0] id, input logic en,
                                       input logic [7:0] d, input logic [3:0] a);
        return {gv, id, en, d, a};
    endfunction

    function automatic logic [15:0] wr(input int o);
        logic [1:0] id;
        id = 2'(o);
        return pk(1'b1, id, 1'b1, 8'(8'h11 * (o + 1)), 4'(4'b0001 << o));
    endfunction

    localparam logic [15:0] QUIET = 16'h0000;

    // Check outputs at the falling edge, then advance to just after the next rising edge.
    task automatic cyc(input string tag, input logic [15:0] exp);
        @(negedge clk);
        if (fifo_w_en) n_wr++;
        chk(tag, 32'({gnt_valid, gnt_id, fifo_w_en, fifo_w_data, ack}), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst              = 1'b0;
        req              = 4'b1111;
        req_data         = {8'h44, 8'h33, 8'h22, 8'h11};
        fifo_full        = 1'b0;
        fifo_almost_full = 1'b0;
        @(posedge clk);
        #1;

        // Reset held with all requests pending
        for (int i = 0; i < 3; i++) cyc("reset_hold", QUIET);
        rst = 1'b1;
        cyc("post_reset_idle", QUIET);

        // Full bursts 0,1,2,3 with one bubble each: 16 words in 20 cycles
        wr_mark = n_wr;
        for (int b = 0; b < 4; b++) begin
            for (int w = 0; w < 4; w++) cyc($sformatf("burst_o%0d_w%0d", b, w), wr(b));
            cyc($sformatf("bubble_after_o%0d", b), QUIET);
        end
        chk("words_in_20_cycles", 32'(n_wr - wr_mark), 32'd16);

        // Owner 0 granted again, then drops its request before any write
        req = 4'b1100;
        cyc("drop_before_write", pk(1'b1, 2'd0, 1'b0, 8'h11, 4'b0000));
        cyc("idle_after_drop", QUIET);

        // Early drop: owner 2 writes two words then releases
        cyc("o2_w0", wr(2));
        cyc("o2_w1", wr(2));
        req = 4'b1000;
        cyc("o2_dropped", pk(1'b1, 2'd2, 1'b0, 8'h33, 4'b0000));
        cyc("idle_after_o2", QUIET);

        // Almost-full on the first write cuts the burst to one word
        fifo_almost_full = 1'b1;
        cyc("o3_af_w0", wr(3));
        fifo_almost_full = 1'b0;
        req = 4'b1111;
        cyc("idle_after_af", QUIET);

        // Full stall mid-burst for owner 0, then the remaining two words
        cyc("o0_w0", wr(0));
        cyc("o0_w1", wr(0));
        fifo_full = 1'b1;
        for (int i = 0; i < 5; i++) cyc("o0_stall", pk(1'b1, 2'd0, 1'b0, 8'h11, 4'b0000));
        fifo_full = 1'b0;
        cyc("o0_w2", wr(0));
        cyc("o0_w3", wr(0));
        cyc("idle_after_o0", QUIET);

        // Full blocks a new grant in IDLE
        cyc("o1_w0", wr(1));
        cyc("o1_w1", wr(1));
        cyc("o1_w2", wr(1));
        cyc("o1_w3", wr(1));
        fifo_full = 1'b1;
        cyc("idle_full", QUIET);
        cyc("idle_full_hold", QUIET);
        fifo_full = 1'b0;
        cyc("idle_full_release", QUIET);

        // Mid-burst reset on owner 2's second word
        cyc("o2b_w0", wr(2));
        rst = 1'b0;
        cyc("midburst_reset", QUIET);
        rst = 1'b1;
        cyc("idle_after_reset", QUIET);
        cyc("restart_o0", wr(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin burst arbiter sharing the write port of one async_fifo between NUM_REQ requesters in the write-clock domain.
- The arbiter grants one requester at a time and forwards that requester's data to the FIFO write port for a burst of up to BURST_LEN words.
- A burst ends early when the requester drops its request or the FIFO signals almost_full.
- The block sits between the producers and async_fifo; its clk is the FIFO's w_clk.

Parameters:
- NUM_REQ, 4: number of requesters; minimum 2.
- DATA_WIDTH, 8: word width; must match async_fifo.
- BURST_LEN, 4: maximum words per grant; minimum 1.
- ID_W, $clog2(NUM_REQ): requester index width (derived).

Ports:
- clk  in  1  write clock; same net as FIFO w_clk.
- rst  in  1  synchronous, active-low reset; sampled on the clk rising edge.
- req  in  NUM_REQ  requester i has a word available on its data lane.
- req_data  in  NUM_REQ*DATA_WIDTH  flattened data lanes; lane i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- ack  out  NUM_REQ  one-hot; lane i's word is consumed on this clk edge.
- fifo_full  in  1  async_fifo full.
- fifo_almost_full  in  1  async_fifo almost_full.
- fifo_w_data  out  DATA_WIDTH  to async_fifo w_data.
- fifo_w_en  out  1  to async_fifo w_en.
- gnt_valid  out  1  a burst is in progress.
- gnt_id  out  ID_W  owner of the current burst.

Behaviour:
- State machine: IDLE and BURST.
- Registers: state, owner (ID_W), last (ID_W), cnt (the width needed to count 0..BURST_LEN-1).
- Reset values: state=IDLE, owner=0, last=NUM_REQ-1 (so requester 0 has first priority), cnt=0.
- While rst=0, all outputs are 0: ack, fifo_w_en, fifo_w_data, gnt_valid, gnt_id.
- Reset mid-burst: the burst is abandoned with no write on that edge.
- IDLE:
  - If |req and !fifo_full, select the first set req bit searching from last+1, wrapping modulo NUM_REQ.
  - On selection: owner<=selected, cnt<=0, state<=BURST.
  - No write is issued in IDLE, so every grant costs one bubble cycle.
- BURST outputs (combinational from registers and inputs):
  - gnt_valid=1, gnt_id=owner.
  - write = req[owner] & !fifo_full.
  - fifo_w_en = write.
  - fifo_w_data = lane owner.
  - ack = write ? (1<<owner) : 0.
- BURST with write=1:
  - cnt<=cnt+1.
  - If cnt==BURST_LEN-1 or fifo_almost_full: state<=IDLE, last<=owner.
- BURST with req[owner]=0: state<=IDLE, last<=owner, no write.
- BURST with req[owner]=1 and fifo_full=1:
  - Stall; hold owner, cnt and state.
  - ack=0, fifo_w_en=0.
  - No timeout: no other requester could write while the FIFO is full.
- Outside BURST, fifo_w_en=0 and ack=0.
- fifo_w_en is never asserted while fifo_full=1; the arbiter never relies on the FIFO's internal full gating.
- Requester rules:
  - Keep req and the lane data stable until ack.
  - May drop req without ack only when not granted. Dropping req mid-burst ends the burst.
- Throughput: at most BURST_LEN words per BURST_LEN+1 cycles per grant.
- Fairness: after a burst, owner becomes lowest priority; any requester waits at most NUM_REQ-1 bursts (excluding full stalls).
- Single requester: re-granted after one IDLE bubble.

Decomposition:
- Package fifo_arb_pkg: state enum (IDLE, BURST) and a function next_rr(req, last) returning the round-robin winner index.
- One natural sub-module, rr_pick: combinational round-robin priority selector (req, last -> id, found), reusable for a future read-side scheduler.
- The FSM, counter and output mux live in fifo_wr_arbiter.

Test Plan:
1. Reset: hold rst=0 for 3 cycles with req=4'b1111 -> all outputs 0; release rst -> IDLE for one cycle, then gnt_id=0 and ack=4'b0001 with lane 0's data on fifo_w_data.
2. Full bursts: all req held, fifo never full, BURST_LEN=4 -> owners 0,1,2,3,0,…; each grant writes 4 words on 4 consecutive edges; 1 bubble between bursts; 16 words in 20 cycles.
3. Early drop: req[2] deasserts after 2 acks -> burst ends with cnt=2, last=2, next grant goes to 3 if requesting.
4. Almost-full cut: fifo_almost_full=1 during the 1st write of a burst -> exactly 1 word written, state returns to IDLE.
5. Full stall: fifo_full rises mid-burst for 5 cycles -> fifo_w_en=0 and ack=0 for 5 cycles, owner and cnt unchanged; the burst then completes its remaining words.
6. Mid-burst reset: rst=0 during the 2nd word -> no ack on that edge; after release, grant order restarts from requester 0.
